// File: rtl/i2cs_pkg.sv
// i2cs_pkg: shared types and default widths for the I2C-slave register
// arbiter. The FSM state enum, the port identifier and the default
// address/data widths live here so the top and the pick logic agree.
package i2cs_pkg;

  localparam int unsigned I2CS_ADDR_W = 8;
  localparam int unsigned I2CS_DATA_W = 8;

  // One cycle per non-IDLE state; IDLE is the only place a grant is made.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } i2cs_state_e;

  // Requester identity, also used as the last-winner pointer.
  typedef enum logic {
    PORT_APB = 1'b0,
    PORT_I2C = 1'b1
  } port_id_e;

endpackage

// File: rtl/i2cs_arb_pick.sv
// i2cs_arb_pick: combinational 2-way winner selection.
// Default: round-robin -- on a tie the port that did not win last time wins.
// With I2CS_ARB_I2C_PRIORITY_EN defined: I2C always wins a tie and the
// last-winner pointer is ignored.
module i2cs_arb_pick
  import i2cs_pkg::*;
(
  input  logic     apb_req_i,
  input  logic     i2c_req_i,
  input  port_id_e last_win_i,
  output logic     grant_o,
  output port_id_e win_o
);

`ifdef I2CS_ARB_I2C_PRIORITY_EN
  // Pointer is not consulted in fixed-priority mode.
  logic w_unused_last;
  assign w_unused_last = last_win_i;
`endif

  // Pick a winner whenever at least one side is requesting.
  always_comb begin
    grant_o = apb_req_i | i2c_req_i;
    win_o   = PORT_APB;
    if (apb_req_i && i2c_req_i) begin
`ifdef I2CS_ARB_I2C_PRIORITY_EN
      win_o = PORT_I2C;
`else
      win_o = (last_win_i == PORT_APB) ? PORT_I2C : PORT_APB;
`endif
    end else if (i2c_req_i) begin
      win_o = PORT_I2C;
    end
  end

endmodule

// File: rtl/i2cs_reg_arbiter.sv
// i2cs_reg_arbiter: arbitrates an APB-side and an I2C-side requester onto a
// single register file. Each access walks IDLE -> ISSUE -> CAPTURE -> DONE.
// Optional build macro: I2CS_ARB_I2C_PRIORITY_EN (I2C wins all ties).
//
// Handshake: a requester raises req with we/addr/wdata stable and holds
// them until its ack pulses (one cycle, in DONE, three cycles after the
// IDLE cycle that sampled req). A req dropped before it is sampled in IDLE
// is ignored; dropping it after the grant does not cancel the access. A req
// still high when the FSM is back in IDLE is a new request.
module i2cs_reg_arbiter
  import i2cs_pkg::*;
#(
  parameter int unsigned ADDR_W = I2CS_ADDR_W,
  parameter int unsigned DATA_W = I2CS_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              apb_req_i,
  input  logic              apb_we_i,
  input  logic [ADDR_W-1:0] apb_addr_i,
  input  logic [DATA_W-1:0] apb_wdata_i,
  output logic              apb_ack_o,
  output logic [DATA_W-1:0] apb_rdata_o,
  input  logic              i2c_req_i,
  input  logic              i2c_we_i,
  input  logic [ADDR_W-1:0] i2c_addr_i,
  input  logic [DATA_W-1:0] i2c_wdata_i,
  output logic              i2c_ack_o,
  output logic [DATA_W-1:0] i2c_rdata_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic [1:0]        dbg_state_o
);

  i2cs_state_e       r_state;
  i2cs_state_e       w_state_nxt;
  port_id_e          r_win;
  port_id_e          r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_apb_rdata;
  logic [DATA_W-1:0] r_i2c_rdata;
  logic              w_grant;
  port_id_e          w_pick;
  logic              w_take;

  i2cs_arb_pick u_pick (
    .apb_req_i  (apb_req_i),
    .i2c_req_i  (i2c_req_i),
    .last_win_i (r_last),
    .grant_o    (w_grant),
    .win_o      (w_pick)
  );

  assign w_take = (r_state == ST_IDLE) && w_grant;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: leave IDLE only on a grant, otherwise one cycle per state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_grant) w_state_nxt = ST_ISSUE;
      ST_ISSUE:   w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_DONE;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winner's access at grant time; pointer moves only on a grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_win   <= PORT_APB;
      r_last  <= PORT_APB;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_take) begin
      r_win  <= w_pick;
      r_last <= w_pick;
      if (w_pick == PORT_I2C) begin
        r_we    <= i2c_we_i;
        r_addr  <= i2c_addr_i;
        r_wdata <= i2c_wdata_i;
      end else begin
        r_we    <= apb_we_i;
        r_addr  <= apb_addr_i;
        r_wdata <= apb_wdata_i;
      end
    end
  end

  // Read data lands in the winner's holding register during CAPTURE only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_apb_rdata <= '0;
      r_i2c_rdata <= '0;
    end else if ((r_state == ST_CAPTURE) && !r_we) begin
      if (r_win == PORT_I2C) r_i2c_rdata <= mem_rdata_i;
      else                   r_apb_rdata <= mem_rdata_i;
    end
  end

  // Register-file strobes are live only in ISSUE; zero everywhere else.
  always_comb begin
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (r_state == ST_ISSUE) begin
      mem_re_o    = !r_we;
      mem_we_o    = r_we;
      mem_addr_o  = r_addr;
      mem_wdata_o = r_wdata;
    end
  end

  assign apb_ack_o   = (r_state == ST_DONE) && (r_win == PORT_APB);
  assign i2c_ack_o   = (r_state == ST_DONE) && (r_win == PORT_I2C);
  assign apb_rdata_o = r_apb_rdata;
  assign i2c_rdata_o = r_i2c_rdata;
  assign busy_o      = (r_state != ST_IDLE);
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_i2cs_reg_arbiter.sv
// tb_i2cs_reg_arbiter: directed bench for i2cs_reg_arbiter with a small
// register-file model, a vector table of single-port accesses, and
// hand-written sequences for arbitration, reset and drop corner cases.
module tb_i2cs_reg_arbiter;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic       apb_req_i, apb_we_i, i2c_req_i, i2c_we_i;
  logic [7:0] apb_addr_i, apb_wdata_i, i2c_addr_i, i2c_wdata_i;
  logic       apb_ack_o, i2c_ack_o, mem_re_o, mem_we_o, busy_o;
  logic [7:0] apb_rdata_o, i2c_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [1:0] dbg_state_o;

  i2cs_reg_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .apb_req_i   (apb_req_i),
    .apb_we_i    (apb_we_i),
    .apb_addr_i  (apb_addr_i),
    .apb_wdata_i (apb_wdata_i),
    .apb_ack_o   (apb_ack_o),
    .apb_rdata_o (apb_rdata_o),
    .i2c_req_i   (i2c_req_i),
    .i2c_we_i    (i2c_we_i),
    .i2c_addr_i  (i2c_addr_i),
    .i2c_wdata_i (i2c_wdata_i),
    .i2c_ack_o   (i2c_ack_o),
    .i2c_rdata_o (i2c_rdata_o),
    .mem_re_o    (mem_re_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- register-file model ----------------
  logic [7:0] mem [256];
  always @(posedge clk_i) begin
    if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
    if (mem_re_o) mem_rdata_i <= mem[mem_addr_o];
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  int         got_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_reqs();
    apb_req_i = 1'b0; apb_we_i = 1'b0; apb_addr_i = 8'h00; apb_wdata_i = 8'h00;
    i2c_req_i = 1'b0; i2c_we_i = 1'b0; i2c_addr_i = 8'h00; i2c_wdata_i = 8'h00;
  endtask

  task automatic drive_req(input logic port, input logic we, input logic [7:0] addr,
                           input logic [7:0] wdata);
    if (port) begin
      i2c_req_i = 1'b1; i2c_we_i = we; i2c_addr_i = addr; i2c_wdata_i = wdata;
    end else begin
      apb_req_i = 1'b1; apb_we_i = we; apb_addr_i = addr; apb_wdata_i = wdata;
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({apb_ack_o, i2c_ack_o, mem_re_o, mem_we_o, busy_o, dbg_state_o}), 32'h0);
    check({name, "_data"}, {apb_rdata_o, i2c_rdata_o, mem_addr_o, mem_wdata_o}, 32'h0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       port;    // 0 = APB, 1 = I2C
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_apb_rd;
    logic [7:0] exp_i2c_rd;
  } vec_t;

  vec_t vecs[6];
  int   apb_pulses;
  int   busy_cycles;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    mem[8'h05] <= 8'hA5;
    mem_rdata_i <= 8'h00;

    vecs[0] = '{1'b0, 1'b0, 8'h05, 8'h00, 8'hA5, 8'h00}; // APB read 0x05
    vecs[1] = '{1'b1, 1'b1, 8'h10, 8'h3C, 8'hA5, 8'h00}; // I2C write 0x10
    vecs[2] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 8'h3C}; // I2C read 0x10
    vecs[3] = '{1'b0, 1'b1, 8'h20, 8'h5A, 8'hA5, 8'h3C}; // APB write 0x20
    vecs[4] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h5A, 8'h3C}; // APB read 0x20
    vecs[5] = '{1'b1, 1'b0, 8'h05, 8'h00, 8'h5A, 8'hA5}; // I2C read 0x05

    // Reset with a live request: reset must win and outputs must be 0.
    clear_reqs();
    rst_i = 1'b1;
    apb_req_i = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst_i = 1'b0;
    clear_reqs();
    tick();

    // Table: one single-port access per entry.
    for (int v = 0; v < 6; v++) begin
      drive_req(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata);
      tick(); // ISSUE
      check($sformatf("v%0d_issue_busy", v), 32'(busy_o), 32'h1);
      check($sformatf("v%0d_issue_re", v), 32'(mem_re_o), 32'(!vecs[v].we));
      check($sformatf("v%0d_issue_we", v), 32'(mem_we_o), 32'(vecs[v].we));
      check($sformatf("v%0d_issue_addr", v), 32'(mem_addr_o), 32'(vecs[v].addr));
      if (vecs[v].we)
        check($sformatf("v%0d_issue_wdata", v), 32'(mem_wdata_o), 32'(vecs[v].wdata));
      tick(); // CAPTURE
      check($sformatf("v%0d_capture_quiet", v),
            32'({mem_re_o, mem_we_o, mem_addr_o, mem_wdata_o, apb_ack_o, i2c_ack_o}), 32'h0);
      tick(); // DONE
      check($sformatf("v%0d_done_apb_ack", v), 32'(apb_ack_o), 32'(!vecs[v].port));
      check($sformatf("v%0d_done_i2c_ack", v), 32'(i2c_ack_o), 32'(vecs[v].port));
      check($sformatf("v%0d_apb_rdata", v), 32'(apb_rdata_o), 32'(vecs[v].exp_apb_rd));
      check($sformatf("v%0d_i2c_rdata", v), 32'(i2c_rdata_o), 32'(vecs[v].exp_i2c_rd));
      clear_reqs();
      tick(); // IDLE
      check($sformatf("v%0d_idle", v), 32'({busy_o, apb_ack_o, i2c_ack_o}), 32'h0);
    end

    // Dropping req after the grant must not cancel the access.
    drive_req(1'b0, 1'b0, 8'h10, 8'h00);
    tick(); // ISSUE
    clear_reqs();
    tick(); // CAPTURE
    tick(); // DONE
    check("late_drop_ack", 32'(apb_ack_o), 32'h1);
    check("late_drop_rdata", 32'(apb_rdata_o), 32'h3C);
    tick();

    // One-cycle APB pulse during an I2C ISSUE is never granted.
    drive_req(1'b1, 1'b1, 8'h30, 8'h77);
    tick(); // ISSUE
    apb_req_i = 1'b1; apb_addr_i = 8'h05;
    tick(); // CAPTURE
    apb_req_i = 1'b0;
    check("pulse_capture_acks", 32'({apb_ack_o, i2c_ack_o}), 32'h0);
    tick(); // DONE
    check("pulse_done_acks", 32'({apb_ack_o, i2c_ack_o}), 32'h1);
    clear_reqs();
    apb_pulses  = 0;
    busy_cycles = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (apb_ack_o) apb_pulses++;
      if (busy_o)    busy_cycles++;
    end
    check("pulse_apb_dropped", 32'(apb_pulses), 32'h0);
    check("pulse_stays_idle", 32'(busy_cycles), 32'h0);

    // Reset during CAPTURE of an APB read: no ack, everything back to 0.
    drive_req(1'b0, 1'b0, 8'h05, 8'h00);
    tick(); // ISSUE
    tick(); // CAPTURE
    rst_i = 1'b1;
    tick();
    check_all_zero("reset_in_capture");
    rst_i = 1'b0;
    clear_reqs();
    tick();
    check("reset_in_capture_no_ack", 32'({apb_ack_o, i2c_ack_o, busy_o}), 32'h0);

    // Both ports requesting continuously straight out of reset.
`ifdef I2CS_ARB_I2C_PRIORITY_EN
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
    rst_i = 1'b1;
    tick();
    tick();
    drive_req(1'b0, 1'b0, 8'h05, 8'h00);
    drive_req(1'b1, 1'b0, 8'h10, 8'h00);
    rst_i = 1'b0;
    for (int c = 1; c <= 40 && got_q.size() < 4; c++) begin
      tick();
      if (apb_ack_o && i2c_ack_o) check("rr_double_ack", 32'h1, 32'h0);
      if (apb_ack_o || i2c_ack_o) begin
        got_q.push_back(i2c_ack_o);
        got_cyc.push_back(c);
      end
    end
    clear_reqs();
    check("rr_grant_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      check("rr_first_latency", 32'(got_cyc[0]), 32'd3);
      for (int i = 0; i < 4; i++)
        check($sformatf("rr_grant%0d_port", i), 32'(got_q[i]), 32'(exp_q[i]));
      for (int i = 1; i < 4; i++)
        check($sformatf("rr_interval%0d", i), 32'(got_cyc[i] - got_cyc[i-1]), 32'd4);
    end
    tick();
    tick();

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
